// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared state type, shift width and saturation helper for requant_relu
package requant_pkg;

  typedef enum logic [2:0] {IDLE, PROC, DRAIN, WRITE, DONE} state_t;

  localparam int SHIFT_WIDTH = 5;

  // Clamp a signed value into the range of a signed number of the given width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/requant_relu_if.sv
// rtl/requant_relu_if.sv - control and vector bus between the GEMV side and requant_relu
interface requant_relu_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ROWS        = 128,
  parameter int LANES       = 8,
  parameter int SCALE_WIDTH = 16
) ();
  import requant_pkg::*;

  logic                              start;
  logic [SCALE_WIDTH-1:0]            scale;
  logic [SHIFT_WIDTH-1:0]            shift;
  logic [0:ROWS-1][DATA_WIDTH-1:0]   in_vec;
  logic [0:ROWS-1][DATA_WIDTH-1:0]   out_vec;
  logic                              busy;
  logic                              done;

  modport master (
    output start, scale, shift, in_vec,
    input  out_vec, busy, done
  );

  modport slave (
    input  start, scale, shift, in_vec,
    output out_vec, busy, done
  );

endinterface

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one-element round/shift/saturate with optional ReLU (REQUANT_RELU_EN)
module requant_lane
  import requant_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PROD_WIDTH = 25
) (
  input  logic signed [PROD_WIDTH-1:0] prod,
  input  logic [SHIFT_WIDTH-1:0]       shift,
  output logic [DATA_WIDTH-1:0]        result
);

  // Work in 64 bits so the rounding bias for any shift up to 31 never wraps.
  logic signed [63:0] wide;
  logic signed [63:0] rounded;

  // Round half toward +inf, arithmetic shift, saturate, then optionally clamp negatives.
  always_comb begin
    wide = {{(64 - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    if (shift != '0) begin
      rounded = (wide + (64'sd1 <<< (shift - 1'b1))) >>> shift;
    end else begin
      rounded = wide;
    end
    result = DATA_WIDTH'(sat_signed(rounded, DATA_WIDTH));
`ifdef REQUANT_RELU_EN
    if (result[DATA_WIDTH-1]) begin
      result = '0;
    end
`endif
  end

endmodule

// File: rtl/requant_relu.sv
// rtl/requant_relu.sv - 2-stage LANES-wide requantise/ReLU of a GEMV result vector (option REQUANT_RELU_EN)
module requant_relu
  import requant_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ROWS        = 128,
  parameter int LANES       = 8,
  parameter int SCALE_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  requant_relu_if.slave   bus
);

  localparam int N  = ROWS / LANES;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = DATA_WIDTH + SCALE_WIDTH + 1;

  typedef logic [0:N-1][0:LANES-1][DATA_WIDTH-1:0] vec_t;

  if (ROWS % LANES != 0) begin : g_rows_check
    $error("requant_relu: ROWS must be a multiple of LANES");
  end

  state_t                          state;
  vec_t                            in_buf;
  vec_t                            res_buf;
  logic [SCALE_WIDTH-1:0]          scale_q;
  logic [SHIFT_WIDTH-1:0]          shift_q;
  logic [IW-1:0]                   idx;
  logic [IW-1:0]                   s1_chunk;
  logic                            s1_valid;
  logic signed [PW-1:0]            s1_prod [LANES];
  logic signed [PW-1:0]            scale_ext;
  logic [0:LANES-1][DATA_WIDTH-1:0] lane_res;

  assign scale_ext = PW'($signed({1'b0, scale_q}));

  // Control FSM plus stage 1: capture operands, then multiply one chunk per PROC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_buf      <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      idx         <= '0;
      s1_chunk    <= '0;
      s1_valid    <= 1'b0;
      for (int l = 0; l < LANES; l++) s1_prod[l] <= '0;
      bus.out_vec <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      s1_valid <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            in_buf   <= bus.in_vec;
            scale_q  <= bus.scale;
            shift_q  <= bus.shift;
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= PROC;
          end
        end
        PROC: begin
          for (int l = 0; l < LANES; l++) begin
            s1_prod[l] <= PW'($signed(in_buf[idx][l])) * scale_ext;
          end
          s1_valid <= 1'b1;
          s1_chunk <= idx;
          if (idx == IW'(N - 1)) begin
            idx   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: state <= WRITE;
        WRITE: begin
          bus.out_vec <= res_buf;
          bus.done    <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .PROD_WIDTH (PW)
    ) u_lane (
      .prod   (s1_prod[g]),
      .shift  (shift_q),
      .result (lane_res[g])
    );
  end

  // Stage 2: store the requantised chunk at its chunk slot whenever stage 1 was valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_buf <= '0;
    end else if (s1_valid) begin
      res_buf[s1_chunk] <= lane_res;
    end
  end

endmodule

// File: tb/tb_requant_relu.sv
// tb/tb_requant_relu.sv - randomized self-checking bench for requant_relu against a timeline model
module tb_requant_relu;

  localparam int DW    = 8;
  localparam int ROWS  = 128;
  localparam int LANES = 8;
  localparam int SW    = 16;

`ifdef REQUANT_RELU_EN
  localparam int EXP_M5   = 0;
  localparam int EXP_M6   = 0;
  localparam int EXP_M100 = 0;
`else
  localparam int EXP_M5   = -7;
  localparam int EXP_M6   = -1;
  localparam int EXP_M100 = -128;
`endif

  typedef logic [0:ROWS-1][DW-1:0] vec_t;

  logic clk;
  logic rst;

  requant_relu_if #(.DATA_WIDTH(DW), .ROWS(ROWS), .LANES(LANES), .SCALE_WIDTH(SW)) bus ();

  requant_relu #(.DATA_WIDTH(DW), .ROWS(ROWS), .LANES(LANES), .SCALE_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;
  int   cyc    = 0;
  bit   chk_en = 0;

  vec_t m_out;
  vec_t m_pend;
  bit   m_active;
  bit   m_busy;
  bit   m_done;
  int   m_age;

  function automatic int ref_elem(int x, int sc, int sh);
    longint p;
    longint r;
    p = longint'(x) * longint'(sc);
    if (sh > 0) r = (p + (64'sd1 <<< (sh - 1))) >>> sh;
    else        r = p;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
`ifdef REQUANT_RELU_EN
    if (r < 0) r = 0;
`endif
    return int'(r);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < ROWS; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  function automatic int elem(int i);
    return int'($signed(bus.out_vec[i]));
  endfunction

  function automatic int vec_errs(vec_t got, vec_t src, int sc, int sh);
    int e = 0;
    for (int i = 0; i < ROWS; i++)
      if (int'($signed(got[i])) != ref_elem(int'($signed(src[i])), sc, sh)) e++;
    return e;
  endfunction

  function automatic int nonzero(vec_t v);
    int e = 0;
    for (int i = 0; i < ROWS; i++) if (v[i] != '0) e++;
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Timeline model: a run accepted at edge E0 shows done after E18 and is idle again after E19.
  initial begin
    m_active = 0; m_busy = 0; m_done = 0; m_age = 0; m_out = '0; m_pend = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 0; m_busy = 0; m_done = 0; m_age = 0; m_out = '0;
      end else begin
        m_done = 0;
        if (m_active) begin
          m_age++;
          if (m_age == 18) begin
            m_out  = m_pend;
            m_done = 1;
          end
          if (m_age == 19) begin
            m_active = 0;
            m_busy   = 0;
          end
        end else if (bus.start) begin
          m_active = 1;
          m_busy   = 1;
          m_age    = 0;
          for (int i = 0; i < ROWS; i++)
            m_pend[i] = DW'(ref_elem(int'($signed(bus.in_vec[i])), int'(bus.scale), int'(bus.shift)));
        end
      end
    end
  end

  // Compare process: every cycle check busy, done and out_vec against the model.
  initial forever begin
    @(negedge clk);
    if (bus.done) n_done++;
    if (chk_en) begin
      check("busy", int'(bus.busy), int'(m_busy));
      check("done", int'(bus.done), int'(m_done));
      n_cmp++;
      if (bus.out_vec !== m_out) begin
        n_bad++;
        $display("FAIL out_vec cycle %0d: got %h expected %h", cyc, bus.out_vec, m_out);
      end
    end
  end

  task automatic scramble();
    bus.in_vec = rand_vec();
    bus.scale  = SW'($urandom);
    bus.shift  = 5'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic run(output int lat);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    check("busy_after_start", int'(bus.busy), 1);
    scramble();
    wait_done(lat);
    @(negedge clk);
    check("busy_after_done", int'(bus.busy), 0);
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    vec_t v;
    int   lat, d0, sc, sh;
    int   tt[3];

    rst = 1; bus.start = 0; bus.scale = '0; bus.shift = '0; bus.in_vec = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_out_nonzero", nonzero(bus.out_vec), 0);
    rst = 0;
    chk_en = 1;
    @(negedge clk);

    check("model_5x3s1", ref_elem(5, 3, 1), 8);
    check("model_m5x3s1", ref_elem(-5, 3, 1), EXP_M5);
    check("model_1x3s1", ref_elem(1, 3, 1), 2);
    check("model_m6x1s2", ref_elem(-6, 1, 2), EXP_M6);
    check("model_sat_hi", ref_elem(100, 200, 0), 127);
    check("model_sat_lo", ref_elem(-100, 200, 0), EXP_M100);
    check("model_big_shift", ref_elem(127, 65535, 31), 0);

    v = rand_vec(); v[0] = 8'd5; v[1] = 8'h80; v[2] = 8'd127;
    bus.in_vec = v; bus.scale = 16'd1; bus.shift = 5'd0;
    run(lat);
    check("identity_latency", lat, 18);
    check("identity_0", elem(0), 5);
    check("identity_1", elem(1), ref_elem(-128, 1, 0));
    check("identity_2", elem(2), 127);
    check("identity_vec", vec_errs(bus.out_vec, v, 1, 0), 0);

    v = rand_vec(); v[0] = 8'd5; v[1] = 8'(-5); v[2] = 8'd1;
    bus.in_vec = v; bus.scale = 16'd3; bus.shift = 5'd1;
    run(lat);
    check("round_5", elem(0), 8);
    check("round_m5", elem(1), EXP_M5);
    check("round_1", elem(2), 2);

    v = rand_vec(); v[0] = 8'(-6);
    bus.in_vec = v; bus.scale = 16'd1; bus.shift = 5'd2;
    run(lat);
    check("round_m6", elem(0), EXP_M6);

    v = rand_vec(); v[0] = 8'd100; v[1] = 8'(-100); v[2] = 8'd0;
    bus.in_vec = v; bus.scale = 16'd200; bus.shift = 5'd0;
    run(lat);
    check("sat_100", elem(0), 127);
    check("sat_m100", elem(1), EXP_M100);
    check("sat_0", elem(2), 0);

    v = rand_vec(); v[0] = 8'd127;
    bus.in_vec = v; bus.scale = 16'hFFFF; bus.shift = 5'd31;
    run(lat);
    check("shift31_127", elem(0), 0);
    check("shift31_vec", vec_errs(bus.out_vec, v, 65535, 31), 0);

    for (int r = 0; r < 8; r++) begin
      v  = rand_vec();
      sc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 300));
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 10));
      bus.in_vec = v; bus.scale = SW'(sc); bus.shift = 5'(sh);
      run(lat);
      check("rand_latency", lat, 18);
      check("rand_vec", vec_errs(bus.out_vec, v, sc, sh), 0);
    end

    v = rand_vec(); sc = 37; sh = 3;
    bus.in_vec = v; bus.scale = SW'(sc); bus.shift = 5'(sh);
    d0 = n_done;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (4) @(negedge clk);
    bus.in_vec = rand_vec(); bus.scale = 16'd9; bus.shift = 5'd0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    wait_done(lat);
    check("ignored_start_vec", vec_errs(bus.out_vec, v, sc, sh), 0);
    repeat (25) @(negedge clk);
    check("single_done", n_done - d0, 1);

    bus.in_vec = rand_vec(); bus.scale = 16'd5; bus.shift = 5'd2;
    bus.start = 1;
    for (int r = 0; r < 3; r++) begin
      wait_done(lat);
      tt[r] = cyc;
      @(negedge clk);
    end
    bus.start = 0;
    check("b2b_gap1", tt[1] - tt[0], 20);
    check("b2b_gap2", tt[2] - tt[1], 20);
    for (int k = 0; k < 40 && bus.busy; k++) @(negedge clk);
    check("b2b_idle", int'(bus.busy), 0);
    @(negedge clk);

    bus.in_vec = rand_vec(); bus.scale = 16'd7; bus.shift = 5'd1;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (8) @(posedge clk);
    #1 rst = 1;
    d0 = n_done;
    @(negedge clk);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_done", int'(bus.done), 0);
    check("midreset_out_nonzero", nonzero(bus.out_vec), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (25) @(negedge clk);
    check("midreset_no_done", n_done - d0, 0);

    v = rand_vec(); v[0] = 8'd5;
    bus.in_vec = v; bus.scale = 16'd3; bus.shift = 5'd1;
    run(lat);
    check("post_reset_latency", lat, 18);
    check("post_reset_5", elem(0), 8);
    check("post_reset_vec", vec_errs(bus.out_vec, v, 3, 1), 0);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
